// File: rtl/packet_generator_pkg.sv
// Shared definitions for the packet generator and its downstream sequence checker.
// Holds FSM encodings, the header f_code and the default field layout.
// Pure declarations; no logic of its own.
package packet_generator_pkg;

   // FSM states, 2-bit encoded
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      INJ_F   = 2'd2,
      INJ_SEQ = 2'd3
   } state_t;

   // Default packet geometry
   localparam int BUS_SIZE_DEF  = 16;
   localparam int WORD_SIZE_DEF = 4;

   // Header value of a good packet: all ones; the checker compares against this
   localparam logic [WORD_SIZE_DEF-1:0] F_CODE = '1;

   // Field offsets for the default geometry
   localparam int HDR_LSB = BUS_SIZE_DEF - WORD_SIZE_DEF;
   localparam int PAY_LSB = WORD_SIZE_DEF;
   localparam int SEQ_LSB = 0;

endpackage

// File: rtl/packet_generator_pkt_assembler.sv
// Packs header, payload and sequence words into one bus-wide packet.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides when the result is registered.
module pkt_assembler
   import packet_generator_pkg::*;
#(
   parameter int BUS_SIZE  = BUS_SIZE_DEF,
   parameter int WORD_SIZE = WORD_SIZE_DEF
) (
   input  logic [WORD_SIZE-1:0]            header,
   input  logic [BUS_SIZE-2*WORD_SIZE-1:0] payload,
   input  logic [WORD_SIZE-1:0]            seq_word,
   output logic [BUS_SIZE-1:0]             data_bus_next
);

   // Header in the top word, sequence in the bottom word, payload between
   assign data_bus_next = {header, payload, seq_word};

endmodule

// File: rtl/packet_generator.sv
// Emits one sequence-numbered packet per enabled cycle, with optional header/sequence error injection.
// Latency: inputs sampled at an edge appear on data_bus right after that edge (1 cycle).
// Backpressure: none; enable=0 pauses emission, data_bus holds, injection requests stay pending.
module packet_generator
   import packet_generator_pkg::*;
#(
   parameter int BUS_SIZE  = BUS_SIZE_DEF,
   parameter int WORD_SIZE = WORD_SIZE_DEF
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            enable,
   input  logic                            inject_f_err,
   input  logic                            inject_seq_err,
   output logic [BUS_SIZE-1:0]             data_bus,
   output logic                            valid,
   output logic                            err_sent,
   output logic [BUS_SIZE-2*WORD_SIZE-1:0] pkt_count
);

   localparam int WORD_NUM = BUS_SIZE / WORD_SIZE;
   localparam int PAY_W    = (WORD_NUM - 2) * WORD_SIZE;
   localparam logic [WORD_SIZE-1:0] HDR_GOOD = {WORD_SIZE{1'b1}};
   localparam logic [WORD_SIZE-1:0] SEQ_INIT = WORD_SIZE'(1);

   state_t               state_q, state_d;
   logic [WORD_SIZE-1:0] seq_q, seq_d;
   logic                 pend_f_q, pend_f_d;
   logic                 pend_seq_q, pend_seq_d;
   logic [WORD_SIZE-1:0] hdr_word;
   logic [WORD_SIZE-1:0] seq_field;
   logic [BUS_SIZE-1:0]  data_bus_next;
   logic [PAY_W-1:0]     payload;

   assign payload = pkt_count;

   pkt_assembler #(
      .BUS_SIZE  (BUS_SIZE),
      .WORD_SIZE (WORD_SIZE)
   ) u_pkt_assembler (
      .header        (hdr_word),
      .payload       (payload),
      .seq_word      (seq_field),
      .data_bus_next (data_bus_next)
   );

   // Next-state, packet fields and pending-flag bookkeeping.
   // A request that triggers its own injection is consumed; a request that
   // arrives while an older pending one is being emitted stays pending.
   always_comb begin
      state_d    = IDLE;
      hdr_word   = HDR_GOOD;
      seq_field  = seq_q;
      seq_d      = seq_q;
      pend_f_d   = pend_f_q | inject_f_err;
      pend_seq_d = pend_seq_q | inject_seq_err;
      if (enable) begin
         if (pend_f_q || inject_f_err) begin
            state_d  = INJ_F;
            hdr_word = '0;
            seq_d    = '0;
            pend_f_d = pend_f_q & inject_f_err;
         end else if (pend_seq_q || inject_seq_err) begin
            state_d    = INJ_SEQ;
            seq_field  = seq_q + 1'b1;
            seq_d      = '0;
            pend_seq_d = pend_seq_q & inject_seq_err;
         end else begin
            state_d = RUN;
            seq_d   = seq_q + 1'b1;
         end
      end
   end

   // State, sequence, pending flags and the registered packet/counter
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         seq_q      <= SEQ_INIT;
         pend_f_q   <= 1'b0;
         pend_seq_q <= 1'b0;
         data_bus   <= '0;
         pkt_count  <= '0;
      end else begin
         state_q    <= state_d;
         seq_q      <= seq_d;
         pend_f_q   <= pend_f_d;
         pend_seq_q <= pend_seq_d;
         if (state_d != IDLE) begin
            data_bus  <= data_bus_next;
            pkt_count <= pkt_count + 1'b1;
         end
      end
   end

   // Status flags decode directly from the registered state
   always_comb begin
      valid    = (state_q != IDLE);
      err_sent = (state_q == INJ_F) || (state_q == INJ_SEQ);
   end

endmodule
